// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg
// Shared types and elaboration-time helpers for the key_pulse_array block.
//   repeat_state_t : auto-repeat FSM state per channel
//   cnt_width()    : bit width needed to hold a counter's largest value
//   max_int()      : larger of two integers, used to size the repeat counter
package key_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  // A counter that only ever reaches 0 still needs one bit.
  function automatic int cnt_width(input int max_value);
    cnt_width = (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_pulse_channel.sv
// key_pulse_channel
// One key channel: polarity normalisation, multi-flop synchroniser,
// counter debounce, press/release strobes and optional auto-repeat.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   key_raw        : asynchronous button input (polarity set by ACTIVE_LOW)
//   pressed        : debounced level, 1 = held
//   press_pulse    : one-cycle strobe in the first cycle pressed reads 1
//   release_pulse  : one-cycle strobe in the first cycle pressed reads 0
//   action         : release strobe (legacy mode) or press strobe plus repeats
module key_pulse_channel
  import key_pulse_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int ACTIVE_LOW       = 1,
  parameter int PULSE_ON_RELEASE = 1,
  parameter int REPEAT_DELAY     = 0,
  parameter int REPEAT_PERIOD    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic action
);

  localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
  localparam logic [RPT_W-1:0] DELAY_END  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] PERIOD_END = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);

  // Repeat only exists in press mode with a non-zero initial delay.
  localparam bit REPEAT_EN = (PULSE_ON_RELEASE == 0) && (REPEAT_DELAY > 0);

  logic                   key_norm;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   level;
  logic [DB_W-1:0]        db_cnt;
  logic                   differs;
  logic                   flip;
  logic                   rise;
  logic                   fall;
  repeat_state_t          state;
  logic [RPT_W-1:0]       rpt_cnt;
  logic                   rpt_strobe;

  assign key_norm = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;
  assign sync_out = sync[SYNC_STAGES-1];

  // Synchroniser: reset loads the released (0) level.
  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], key_norm};
  end

  // Debounce: the level flips on the DEBOUNCE_CYCLES-th consecutive
  // disagreeing sample; any agreeing sample restarts the count.
  assign differs = (sync_out != level);
  assign flip    = differs && (db_cnt == DB_LAST);
  assign rise    = flip && !level;
  assign fall    = flip && level;

  always_ff @(posedge clk) begin
    if (reset) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      if (!differs || flip) db_cnt <= '0;
      else                  db_cnt <= db_cnt + DB_ONE;
      if (flip) level <= ~level;
    end
  end

  // Strobes are registered from the same edge that updates level, so they
  // coincide with the first cycle the new level is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
    end
  end

  // Auto-repeat: the counter holds the number of cycles elapsed since the
  // last strobe (1 in the strobe cycle). A release on the expiry edge
  // takes priority and suppresses the repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rpt_cnt    <= '0;
      rpt_strobe <= 1'b0;
    end else begin
      rpt_strobe <= 1'b0;
      if (fall) begin
        state   <= IDLE;
        rpt_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise && REPEAT_EN) begin
              state   <= DELAY;
              rpt_cnt <= RPT_ONE;
            end
          end
          DELAY: begin
            if (rpt_cnt == DELAY_END) begin
              rpt_strobe <= 1'b1;
              rpt_cnt    <= RPT_ONE;
              state      <= REPEAT;
            end else begin
              rpt_cnt <= rpt_cnt + RPT_ONE;
            end
          end
          REPEAT: begin
            if (rpt_cnt == PERIOD_END) begin
              rpt_strobe <= 1'b1;
              rpt_cnt    <= RPT_ONE;
            end else begin
              rpt_cnt <= rpt_cnt + RPT_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            rpt_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign pressed = level;
  assign action  = (PULSE_ON_RELEASE != 0) ? release_pulse
                                           : (press_pulse | rpt_strobe);

endmodule

// File: rtl/key_pulse_array.sv
// key_pulse_array
// N_KEYS independent debounced key channels for the game controls.
// Bit i of every vector port belongs to channel i.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   key_raw        : asynchronous button inputs
//   pressed        : debounced levels, 1 = held
//   press_pulse    : one-cycle strobes on debounced press
//   release_pulse  : one-cycle strobes on debounced release
//   action         : one-cycle action strobes (release, or press + repeats)
module key_pulse_array
  import key_pulse_pkg::*;
#(
  parameter int N_KEYS           = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 16,
  parameter int ACTIVE_LOW       = 1,
  parameter int PULSE_ON_RELEASE = 1,
  parameter int REPEAT_DELAY     = 0,
  parameter int REPEAT_PERIOD    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] action
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_pulse_channel #(
      .SYNC_STAGES      (SYNC_STAGES),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW),
      .PULSE_ON_RELEASE (PULSE_ON_RELEASE),
      .REPEAT_DELAY     (REPEAT_DELAY),
      .REPEAT_PERIOD    (REPEAT_PERIOD)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .key_raw       (key_raw[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .action        (action[i])
    );
  end

endmodule
